// File: rtl/op_digit_scheduler_if.sv
// op_digit_scheduler_if: groups the request, shared-unit and digit-stream
// signals of op_digit_scheduler.
//   master : scheduler side. Drives req_ready, unit_op/unit_x/unit_y,
//            dig_valid/dig_data/dig_idx/dig_last and busy.
//   slave  : environment side (requester, combinational digit unit,
//            digit consumer). Drives req_valid/req_op/req_x/req_y,
//            unit_d and dig_ready.
interface op_digit_scheduler_if;
    localparam int unsigned OpW   = 2;
    localparam int unsigned OperW = 6;
    localparam int unsigned DataW = 24;
    localparam int unsigned DigW  = 4;
    localparam int unsigned IdxW  = 3;

    logic             req_valid;
    logic             req_ready;
    logic [OpW-1:0]   req_op;
    logic [OperW-1:0] req_x;
    logic [OperW-1:0] req_y;

    logic [OpW-1:0]   unit_op;
    logic [OperW-1:0] unit_x;
    logic [OperW-1:0] unit_y;
    logic [DataW-1:0] unit_d;

    logic             dig_valid;
    logic             dig_ready;
    logic [DigW-1:0]  dig_data;
    logic [IdxW-1:0]  dig_idx;
    logic             dig_last;
    logic             busy;

    modport master (
        input  req_valid, req_op, req_x, req_y, unit_d, dig_ready,
        output req_ready, unit_op, unit_x, unit_y,
               dig_valid, dig_data, dig_idx, dig_last, busy
    );

    modport slave (
        output req_valid, req_op, req_x, req_y, unit_d, dig_ready,
        input  req_ready, unit_op, unit_x, unit_y,
               dig_valid, dig_data, dig_idx, dig_last, busy
    );
endinterface

// File: rtl/op_digit_scheduler.sv
// op_digit_scheduler: accepts one operation, presents its operands to a
// shared combinational digit unit, waits SETTLE cycles for the unit to
// settle, captures all six result digits and streams them d1..d6 over a
// valid/ready digit channel.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    op_digit_scheduler_if.master
//            request : req_valid/req_ready/req_op/req_x/req_y
//            unit    : unit_op/unit_x/unit_y out, unit_d in
//            digits  : dig_valid/dig_ready/dig_data/dig_idx/dig_last
//            status  : busy
// SETTLE: cycles the unit inputs are held before capture, legal 1..7.
module op_digit_scheduler #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    op_digit_scheduler_if.master bus
);
    localparam int unsigned CntW  = 3;
    localparam int unsigned IdxW  = 3;
    localparam int unsigned DigW  = 4;
    localparam int unsigned OpW   = 2;
    localparam int unsigned OperW = 6;
    localparam int unsigned DataW = 24;

    localparam logic [IdxW-1:0] LastIdx    = IdxW'(5);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);

    typedef enum logic [1:0] {
        sIdle,
        sSettle,
        sSend
    } stateT;

    stateT             state;
    logic [CntW-1:0]   settleCnt;
    logic [DataW-1:0]  digitReg;
    logic [OpW-1:0]    unitOp;
    logic [OperW-1:0]  unitX;
    logic [OperW-1:0]  unitY;
    logic              digValid;
    logic [DigW-1:0]   digData;
    logic [IdxW-1:0]   digIdx;
    logic              digLast;
    logic              busyR;

    // Request handshake is a pure state decode so an accept needs no extra cycle.
    assign bus.req_ready = (state == sIdle);

    assign bus.unit_op   = unitOp;
    assign bus.unit_x    = unitX;
    assign bus.unit_y    = unitY;
    assign bus.dig_valid = digValid;
    assign bus.dig_data  = digData;
    assign bus.dig_idx   = digIdx;
    assign bus.dig_last  = digLast;
    assign bus.busy      = busyR;

    // Control FSM with registered outputs.
    // digitReg shifts right one digit per transfer, so the next digit to
    // present is always in its second nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= sIdle;
            settleCnt <= '0;
            digitReg  <= '0;
            unitOp    <= '0;
            unitX     <= '0;
            unitY     <= '0;
            digValid  <= 1'b0;
            digData   <= '0;
            digIdx    <= '0;
            digLast   <= 1'b0;
            busyR     <= 1'b0;
        end else begin
            case (state)
                sIdle: begin
                    if (bus.req_valid) begin
                        unitOp    <= bus.req_op;
                        unitX     <= bus.req_x;
                        unitY     <= bus.req_y;
                        settleCnt <= SettleLoad;
                        busyR     <= 1'b1;
                        state     <= sSettle;
                    end
                end

                sSettle: begin
                    if (settleCnt == '0) begin
                        digitReg <= bus.unit_d;
                        digData  <= bus.unit_d[DigW-1:0];
                        digIdx   <= '0;
                        digLast  <= 1'b0;
                        digValid <= 1'b1;
                        state    <= sSend;
                    end else begin
                        settleCnt <= settleCnt - CntW'(1);
                    end
                end

                sSend: begin
                    // digValid is always 1 here, so dig_ready alone marks a transfer.
                    if (bus.dig_ready) begin
                        if (digIdx == LastIdx) begin
                            digValid <= 1'b0;
                            digData  <= '0;
                            digIdx   <= '0;
                            digLast  <= 1'b0;
                            busyR    <= 1'b0;
                            state    <= sIdle;
                        end else begin
                            digitReg <= {DigW'(0), digitReg[DataW-1:DigW]};
                            digData  <= digitReg[2*DigW-1:DigW];
                            digIdx   <= digIdx + IdxW'(1);
                            digLast  <= (digIdx == LastIdx - IdxW'(1));
                        end
                    end
                end

                default: state <= sIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_op_digit_scheduler.sv
// tb_op_digit_scheduler: directed bench for op_digit_scheduler. A decimal
// digit unit model sits on unit_d; every accepted request queues the six
// digits the unit must deliver, and a compare process checks each
// presented digit against that queue.
module tb_op_digit_scheduler;
    typedef struct packed {
        logic [3:0] data;
        logic [2:0] idx;
    } digT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        reqValid;
    logic [1:0]  reqOp;
    logic [5:0]  reqX;
    logic [5:0]  reqY;
    logic        digReady;
    logic        unitForce;
    logic [23:0] forceVal;
    logic        latValid;
    logic [3:0]  stamp;
    logic        patEn;
    logic [3:0]  pat = 4'b1001;
    int          patPos = 0;

    int nChecks = 0;
    int nErrors = 0;

    digT        expQ[$];
    logic [3:0] gotQ[$];

    logic [3:0] litA [6] = '{4'd9, 4'd2, 4'd5, 4'd0, 4'd0, 4'd0};
    logic [3:0] litC [6] = '{4'd7, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] litD [6] = '{4'hC, 4'hA, 4'h3, 4'hC, 4'h2, 4'h1};
    logic [3:0] litE [6] = '{4'd5, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};

    // Decimal digits of v, d1 in the low nibble.
    function automatic logic [23:0] toDigits(input int v);
        logic [23:0] d;
        int r;
        d = '0;
        r = v;
        for (int i = 0; i < 6; i++) begin
            d[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return d;
    endfunction

    function automatic int unitCalc(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y);
        case (op)
            2'd0:    return int'(x) + int'(y);
            2'd1:    return int'(x) * int'(y);
            2'd2:    return int'(x);
            default: return int'(x) * int'(x);
        endcase
    endfunction

    op_digit_scheduler_if bus ();
    op_digit_scheduler_if bus1 ();
    op_digit_scheduler_if bus7 ();

    op_digit_scheduler #(.SETTLE(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    op_digit_scheduler #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    op_digit_scheduler #(.SETTLE(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));

    assign bus.req_valid = reqValid;
    assign bus.req_op    = reqOp;
    assign bus.req_x     = reqX;
    assign bus.req_y     = reqY;
    assign bus.dig_ready = digReady;
    assign bus.unit_d    = unitForce ? forceVal : toDigits(unitCalc(bus.unit_op, bus.unit_x, bus.unit_y));

    // Latency instances see a stamp equal to the number of edges since accept.
    assign bus1.req_valid = latValid;
    assign bus1.req_op    = 2'd0;
    assign bus1.req_x     = 6'd0;
    assign bus1.req_y     = 6'd0;
    assign bus1.dig_ready = 1'b1;
    assign bus1.unit_d    = {20'h0, stamp};
    assign bus7.req_valid = latValid;
    assign bus7.req_op    = 2'd0;
    assign bus7.req_x     = 6'd0;
    assign bus7.req_y     = 6'd0;
    assign bus7.dig_ready = 1'b1;
    assign bus7.unit_d    = {20'h0, stamp};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          stamp <= 4'd0;
        else if (latValid && stamp == 4'd0)  stamp <= 4'd1;
        else if (stamp != 4'd0 && stamp != 4'hF) stamp <= stamp + 4'd1;
    end

    // dig_ready pattern 1,0,0,1 when enabled.
    always @(posedge clk) begin
        #1;
        if (patEn) begin
            digReady = pat[patPos % 4];
            patPos++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectDigits(input logic [23:0] d);
        for (int i = 0; i < 6; i++)
            expQ.push_back(digT'{data: d[i*4 +: 4], idx: 3'(i)});
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (bus.dig_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            nChecks++;
            nErrors++;
            $display("FAIL %s_timeout actual=busy expected=idle", tag);
        end
    endtask

    task automatic checkGot(input string tag, input logic [3:0] lit [6]);
        chk({tag, "_count"}, 32'(gotQ.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < gotQ.size())
                chk($sformatf("%s_d%0d", tag, i + 1), 32'(gotQ[i]), 32'(lit[i]));
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_dig_valid"}, 32'(bus.dig_valid), 32'd0);
        chk({tag, "_dig_data"},  32'(bus.dig_data),  32'd0);
        chk({tag, "_dig_idx"},   32'(bus.dig_idx),   32'd0);
        chk({tag, "_dig_last"},  32'(bus.dig_last),  32'd0);
        chk({tag, "_unit_op"},   32'(bus.unit_op),   32'd0);
        chk({tag, "_unit_x"},    32'(bus.unit_x),    32'd0);
        chk({tag, "_unit_y"},    32'(bus.unit_y),    32'd0);
    endtask

    // Per-cycle compare against the expected digit queue.
    logic       prevHold = 1'b0;
    logic [3:0] prevData;
    logic [2:0] prevIdx;
    always @(negedge clk) begin
        if (!rst_n) begin
            prevHold = 1'b0;
        end else begin
            chk("req_ready_vs_busy", 32'(bus.req_ready), 32'(!bus.busy));
            if (bus.dig_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("FAIL unexpected_digit actual=valid_idx%0d expected=no_digit", bus.dig_idx);
                end else begin
                    chk("dig_data", 32'(bus.dig_data), 32'(expQ[0].data));
                    chk("dig_idx",  32'(bus.dig_idx),  32'(expQ[0].idx));
                    chk("dig_last", 32'(bus.dig_last), 32'(expQ[0].idx == 3'd5));
                    if (prevHold) begin
                        chk("hold_data", 32'(bus.dig_data), 32'(prevData));
                        chk("hold_idx",  32'(bus.dig_idx),  32'(prevIdx));
                    end
                    if (digReady) begin
                        gotQ.push_back(bus.dig_data);
                        void'(expQ.pop_front());
                    end
                end
                prevHold = !digReady;
                prevData = bus.dig_data;
                prevIdx  = bus.dig_idx;
            end else begin
                prevHold = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k1;
        int k7;
        logic [3:0] d1v;
        logic [3:0] d7v;

        rst_n     = 1'b0;
        reqValid  = 1'b0;
        reqOp     = 2'd0;
        reqX      = 6'd0;
        reqY      = 6'd0;
        digReady  = 1'b0;
        unitForce = 1'b0;
        forceVal  = 24'h0;
        latValid  = 1'b0;
        patEn     = 1'b0;

        #12;
        checkReset("reset");

        // Square of 23 = 529; first accept at the first edge after release.
        @(negedge clk);
        #1;
        reqValid = 1'b1; reqOp = 2'd3; reqX = 6'd23; reqY = 6'd0;
        expectDigits(toDigits(529));
        rst_n = 1'b1;
        tick();
        chk("A_unit_op", 32'(bus.unit_op), 32'd3);
        chk("A_unit_x",  32'(bus.unit_x),  32'd23);
        chk("A_unit_y",  32'(bus.unit_y),  32'd0);
        chk("A_busy",    32'(bus.busy),    32'd1);
        chk("A_ready",   32'(bus.req_ready), 32'd0);
        reqValid = 1'b0;
        waitValid(n);
        chk("A_capture_latency", 32'(n), 32'd2);
        chk("A_unit_x_hold", 32'(bus.unit_x), 32'd23);
        patEn = 1'b1;
        waitIdle("A");
        patEn = 1'b0;
        digReady = 1'b0;
        checkGot("A", litA);
        chk("A_unit_x_idle", 32'(bus.unit_x), 32'd23);

        // Back-to-back with req_valid held: 12*34=408 then 50+13=63.
        gotQ.delete();
        reqValid = 1'b1; reqOp = 2'd1; reqX = 6'd12; reqY = 6'd34;
        expectDigits(toDigits(408));
        tick();
        chk("B1_unit_x", 32'(bus.unit_x), 32'd12);
        reqOp = 2'd0; reqX = 6'd50; reqY = 6'd13;
        expectDigits(toDigits(63));
        digReady = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("B_idle_after", 32'(n), 32'd8);
        chk("B_idle_count", 32'(gotQ.size()), 32'd6);
        chk("B_idle_busy",  32'(bus.busy), 32'd0);
        chk("B_idle_valid", 32'(bus.dig_valid), 32'd0);
        chk("B_hold_x_idle", 32'(bus.unit_x), 32'd12);
        tick();
        chk("B2_busy",    32'(bus.busy), 32'd1);
        chk("B2_ready",   32'(bus.req_ready), 32'd0);
        chk("B2_unit_op", 32'(bus.unit_op), 32'd0);
        chk("B2_unit_x",  32'(bus.unit_x), 32'd50);
        chk("B2_unit_y",  32'(bus.unit_y), 32'd13);
        reqValid = 1'b0;
        waitIdle("B2");
        digReady = 1'b0;
        chk("B_total", 32'(gotQ.size()), 32'd12);

        // unit_d turns to all-F right after capture.
        gotQ.delete();
        reqValid = 1'b1; reqOp = 2'd2; reqX = 6'd47; reqY = 6'd9;
        expectDigits(toDigits(47));
        tick();
        reqValid = 1'b0;
        waitValid(n);
        chk("C_capture_latency", 32'(n), 32'd2);
        forceVal  = 24'hFFFFFF;
        unitForce = 1'b1;
        tick();
        tick();
        digReady = 1'b1;
        waitIdle("C");
        digReady = 1'b0;
        checkGot("C", litC);

        // Digits above 9 pass through untouched.
        gotQ.delete();
        forceVal = 24'h12C3AC;
        reqValid = 1'b1; reqOp = 2'd0; reqX = 6'd1; reqY = 6'd2;
        expectDigits(24'h12C3AC);
        tick();
        reqValid = 1'b0;
        patPos = 0;
        patEn = 1'b1;
        waitIdle("D");
        patEn = 1'b0;
        digReady = 1'b0;
        unitForce = 1'b0;
        checkGot("D", litD);

        // Reset in SEND at index 3: 63*63 = 3969.
        gotQ.delete();
        reqValid = 1'b1; reqOp = 2'd1; reqX = 6'd63; reqY = 6'd63;
        expectDigits(toDigits(3969));
        tick();
        reqValid = 1'b0;
        digReady = 1'b1;
        n = 0;
        while (!(bus.dig_valid === 1'b1 && bus.dig_idx === 3'd3) && n < 40) begin
            tick();
            n++;
        end
        chk("E_reach_idx3", 32'(bus.dig_idx), 32'd3);
        rst_n = 1'b0;
        #2;
        checkReset("E_reset");
        expQ.delete();
        chk("E_partial_count", 32'(gotQ.size()), 32'd3);
        gotQ.delete();
        @(negedge clk);
        #1;
        reqValid = 1'b1; reqOp = 2'd3; reqX = 6'd5; reqY = 6'd0;
        expectDigits(toDigits(25));
        rst_n = 1'b1;
        tick();
        chk("E_restart_x", 32'(bus.unit_x), 32'd5);
        reqValid = 1'b0;
        digReady = 1'b0;
        waitValid(n);
        chk("E_restart_idx", 32'(bus.dig_idx), 32'd0);
        digReady = 1'b1;
        waitIdle("E");
        digReady = 1'b0;
        checkGot("E", litE);

        // SETTLE=1 and SETTLE=7 capture latency.
        latValid = 1'b1;
        tick();
        latValid = 1'b0;
        k1 = 0; k7 = 0; d1v = 4'd0; d7v = 4'd0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k1 == 0 && bus1.dig_valid === 1'b1) begin k1 = k; d1v = bus1.dig_data; end
            if (k7 == 0 && bus7.dig_valid === 1'b1) begin k7 = k; d7v = bus7.dig_data; end
        end
        chk("S1_first_valid", 32'(k1), 32'd1);
        chk("S1_capture_edge", 32'(d1v), 32'd1);
        chk("S7_first_valid", 32'(k7), 32'd7);
        chk("S7_capture_edge", 32'(d7v), 32'd7);

        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
